// File: rtl/cv32e41s_pmp_imp_arbiter.sv
// Shares one implicit-access memory port between the IF and LSU MPUs, one transaction at a time.
// Optional response watchdog and drain state are built when CV32E41S_PMP_IMP_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no transaction outstanding, arbitrate on any request
// REQ   | mem_req_o high with addr_q, waiting for mem_gnt_i
// WAIT  | granted, waiting for mem_rvalid_i to route to the owner
// DRAIN | watchdog answered the owner; swallow the late memory response
module cv32e41s_pmp_imp_arbiter #(
  parameter int unsigned ARB_ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rvalid_o,

  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  output logic        lsu_rvalid_o,

  output logic [31:0] rdata_b0_o,
  output logic [31:0] rdata_b1_o,
  output logic        err_o,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_b0_i,
  input  logic [31:0] mem_rdata_b1_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
  localparam logic [1:0]  S_DRAIN  = 2'd3;
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);
`endif

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic        mem_req_q, mem_req_d;
  logic        winner;
  logic        rsp_ok;
  logic        tmo_fire;
  logic        rsp_vld;

  // On a tie, round-robin hands the port to whoever was not served last.
  always_comb begin
    winner = OWN_IF;
    if (if_req_i && lsu_req_i) begin
      winner = (ARB_ROUND_ROBIN != 0) ? ~last_q : OWN_LSU;
    end else if (lsu_req_i) begin
      winner = OWN_LSU;
    end
  end

  assign rsp_ok = (state_q == S_WAIT) && mem_rvalid_i;

`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Down-counter loaded while idle, so it starts full on the first REQ cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (state_q == S_IDLE) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (((state_q == S_REQ) || (state_q == S_WAIT)) && (tmo_cnt_q != 16'd0)) begin
      tmo_cnt_q <= tmo_cnt_q - 16'd1;
    end
  end

  // A response landing in the terminal cycle beats the watchdog.
  assign tmo_fire = ((state_q == S_REQ) || ((state_q == S_WAIT) && !mem_rvalid_i)) &&
                    (tmo_cnt_q == 16'd0);
  assign err_o    = tmo_fire && !rst;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYCLES;
  assign tmo_fire       = 1'b0;
  assign err_o          = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    mem_req_d = mem_req_q;
    case (state_q)
      S_IDLE: begin
        if (if_req_i || lsu_req_i) begin
          owner_d   = winner;
          addr_d    = (winner == OWN_LSU) ? lsu_addr_i : if_addr_i;
          mem_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end
      end
`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
      S_DRAIN: begin
        if (mem_req_q) begin
          if (mem_gnt_i) begin
            mem_req_d = 1'b0;
          end
        end else if (mem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
    if (tmo_fire) begin
      last_d  = owner_q;
      state_d = S_DRAIN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IF;
      last_q    <= OWN_LSU;
      addr_q    <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      mem_req_q <= mem_req_d;
    end
  end

  // Reset masks the outputs in the very cycle it is asserted, so an abandoned
  // transaction can never leak a response.
  assign rsp_vld      = (rsp_ok || tmo_fire) && !rst;
  assign if_rvalid_o  = rsp_vld && (owner_q == OWN_IF);
  assign lsu_rvalid_o = rsp_vld && (owner_q == OWN_LSU);
  assign rdata_b0_o   = (rsp_ok && !rst) ? mem_rdata_b0_i : 32'd0;
  assign rdata_b1_o   = (rsp_ok && !rst) ? mem_rdata_b1_i : 32'd0;
  assign mem_req_o    = mem_req_q && !rst;
  assign mem_addr_o   = mem_req_o ? addr_q : 32'd0;

endmodule

// File: tb/tb_cv32e41s_pmp_imp_arbiter.sv
// Bench for cv32e41s_pmp_imp_arbiter: instance 0 is round-robin (watchdog 255),
// instance 1 is fixed-priority with a 4-cycle watchdog.
module tb_cv32e41s_pmp_imp_arbiter;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;
  localparam int RAND_N = 100;

  typedef struct {
    int          dut;
    bit          rst;
    bit          ifr;
    logic [31:0] ifa;
    bit          lsur;
    logic [31:0] lsua;
    int          gd;
    int          rd;
    logic [31:0] b0;
    logic [31:0] b1;
    bit          exp_lsu;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        if_req     [2];
  logic [31:0] if_addr    [2];
  logic        if_rv      [2];
  logic        lsu_req    [2];
  logic [31:0] lsu_addr   [2];
  logic        lsu_rv     [2];
  logic [31:0] rd_b0      [2];
  logic [31:0] rd_b1      [2];
  logic        err        [2];
  logic        mem_req    [2];
  logic [31:0] mem_addr   [2];
  logic        mem_gnt    [2];
  logic        mem_rvalid [2];
  logic [31:0] mem_b0     [2];
  logic [31:0] mem_b1     [2];

  int errors = 0;
  int checks = 0;
  vec_t tbl[12];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cv32e41s_pmp_imp_arbiter #(
      .ARB_ROUND_ROBIN((g == 0) ? 1 : 0),
      .TIMEOUT_CYCLES ((g == 0) ? 255 : 4)
    ) u_dut (
      .clk           (clk),
      .rst           (rst[g]),
      .if_req_i      (if_req[g]),
      .if_addr_i     (if_addr[g]),
      .if_rvalid_o   (if_rv[g]),
      .lsu_req_i     (lsu_req[g]),
      .lsu_addr_i    (lsu_addr[g]),
      .lsu_rvalid_o  (lsu_rv[g]),
      .rdata_b0_o    (rd_b0[g]),
      .rdata_b1_o    (rd_b1[g]),
      .err_o         (err[g]),
      .mem_req_o     (mem_req[g]),
      .mem_addr_o    (mem_addr[g]),
      .mem_gnt_i     (mem_gnt[g]),
      .mem_rvalid_i  (mem_rvalid[g]),
      .mem_rdata_b0_i(mem_b0[g]),
      .mem_rdata_b1_i(mem_b1[g])
    );
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic sett();
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rv(input int d, input string name, input logic [1:0] exp);
    chk(name, {62'd0, lsu_rv[d], if_rv[d]}, {62'd0, exp});
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_ctl"}, {60'd0, mem_req[d], if_rv[d], lsu_rv[d], err[d]}, 64'd0);
    chk({tag, "_dat"}, {rd_b0[d], rd_b1[d]}, 64'd0);
    chk({tag, "_adr"}, {32'd0, mem_addr[d]}, 64'd0);
  endtask

  function automatic vec_t mk(int dut, bit r, bit ifr, logic [31:0] ifa, bit lsur,
                              logic [31:0] lsua, int gd, int rd, logic [31:0] b0,
                              logic [31:0] b1, bit el, logic [31:0] ea);
    vec_t v;
    v.dut = dut; v.rst = r; v.ifr = ifr; v.ifa = ifa; v.lsur = lsur; v.lsua = lsua;
    v.gd = gd; v.rd = rd; v.b0 = b0; v.b1 = b1; v.exp_lsu = el; v.exp_addr = ea;
    return v;
  endfunction

  // One full transaction starting from an IDLE cycle: request levels, grant delay,
  // response delay, expected owner/address. The owner drops its request afterwards.
  task automatic run_row(input vec_t v, input int idx);
    int d;
    d = v.dut;
    if (v.rst) begin
      if_req[d] = 1'b0; lsu_req[d] = 1'b0; mem_gnt[d] = 1'b0; mem_rvalid[d] = 1'b0;
      rst[d] = 1'b1;
      nxt();
      sett();
      chk_idle(d, $sformatf("r%0d_rst", idx));
      rst[d] = 1'b0;
    end
    if_req[d] = v.ifr;   if_addr[d]  = v.ifa;
    lsu_req[d] = v.lsur; lsu_addr[d] = v.lsua;
    sett();
    chk_idle(d, $sformatf("r%0d_idle", idx));
    nxt();
    for (int k = 0; k <= v.gd; k++) begin
      mem_gnt[d] = (k == v.gd);
      mem_b0[d] = $urandom; mem_b1[d] = $urandom;
      sett();
      chk($sformatf("r%0d_req", idx), {63'd0, mem_req[d]}, 64'd1);
      chk($sformatf("r%0d_addr", idx), {32'd0, mem_addr[d]}, {32'd0, v.exp_addr});
      chk_rv(d, $sformatf("r%0d_rv_in_req", idx), 2'b00);
      nxt();
    end
    mem_gnt[d] = 1'b0;
    for (int k = 0; k <= v.rd; k++) begin
      mem_rvalid[d] = (k == v.rd);
      mem_b0[d] = (k == v.rd) ? v.b0 : $urandom;
      mem_b1[d] = (k == v.rd) ? v.b1 : $urandom;
      sett();
      chk($sformatf("r%0d_req_wait", idx), {63'd0, mem_req[d]}, 64'd0);
      if (k < v.rd) begin
        chk_rv(d, $sformatf("r%0d_rv_early", idx), 2'b00);
        chk($sformatf("r%0d_dat_early", idx), {rd_b0[d], rd_b1[d]}, 64'd0);
      end else begin
        chk_rv(d, $sformatf("r%0d_owner", idx), v.exp_lsu ? 2'b10 : 2'b01);
        chk($sformatf("r%0d_data", idx), {rd_b0[d], rd_b1[d]}, {v.b0, v.b1});
        chk($sformatf("r%0d_err", idx), {63'd0, err[d]}, 64'd0);
      end
      nxt();
    end
    mem_rvalid[d] = 1'b0;
    if (v.exp_lsu) lsu_req[d] = 1'b0;
    else if_req[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; if_req[d] = 1'b0; lsu_req[d] = 1'b0; if_addr[d] = '0; lsu_addr[d] = '0;
      mem_gnt[d] = 1'b0; mem_rvalid[d] = 1'b0; mem_b0[d] = '0; mem_b1[d] = '0;
    end
    nxt();
    nxt();
    sett();
    chk_idle(0, "por0");
    chk_idle(1, "por1");
    rst[0] = 1'b0; rst[1] = 1'b0;

    tbl[0]  = mk(0, Y, Y, 32'h0000_1000, N, 32'h0, 0, 0, 32'hA5A5_0001, 32'h5A5A_0002, N, 32'h0000_1000);
    tbl[1]  = mk(0, Y, Y, 32'h100, Y, 32'h200, 0, 0, 32'h1111_0000, 32'h2222_0000, N, 32'h100);
    tbl[2]  = mk(0, N, Y, 32'h100, Y, 32'h200, 1, 0, 32'h3333_0000, 32'h4444_0000, Y, 32'h200);
    tbl[3]  = mk(0, N, Y, 32'h100, Y, 32'h200, 0, 1, 32'h5555_0000, 32'h6666_0000, N, 32'h100);
    tbl[4]  = mk(0, N, N, 32'h0,   Y, 32'h200, 2, 2, 32'h7777_0000, 32'h8888_0000, Y, 32'h200);
    tbl[5]  = mk(1, Y, Y, 32'h100, Y, 32'h200, 0, 0, 32'h9999_0000, 32'hAAAA_0000, Y, 32'h200);
    tbl[6]  = mk(1, N, Y, 32'h100, Y, 32'h200, 0, 1, 32'hBBBB_0000, 32'hCCCC_0000, Y, 32'h200);
    tbl[7]  = mk(1, N, Y, 32'h100, Y, 32'h200, 1, 0, 32'hDDDD_0000, 32'hEEEE_0000, Y, 32'h200);
    tbl[8]  = mk(1, N, Y, 32'h100, N, 32'h0,   1, 2, 32'h0BAD_F00D, 32'hC0DE_0001, N, 32'h100);
    tbl[9]  = mk(1, N, N, 32'h0,   Y, 32'hFFFF_FFFC, 0, 0, 32'h1234_5678, 32'h8765_4321, Y, 32'hFFFF_FFFC);
    tbl[10] = mk(0, N, Y, 32'hFFFF_FFFC, N, 32'h0, 0, 0, 32'hFFFF_FFFF, 32'h0000_0000, N, 32'hFFFF_FFFC);
    tbl[11] = mk(0, N, N, 32'h0,   Y, 32'h0000_0004, 0, 0, 32'h0000_0001, 32'hFFFF_FFFE, Y, 32'h0000_0004);
    for (int i = 0; i < 12; i++) run_row(tbl[i], i);

    // Grant withheld 5 cycles, with a stray memory rvalid during REQ.
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_3000;
    nxt();
    for (int c = 1; c <= 6; c++) begin
      mem_gnt[0] = (c == 6); mem_rvalid[0] = (c == 3);
      mem_b0[0] = $urandom; mem_b1[0] = $urandom;
      sett();
      chk($sformatf("hold_req_c%0d", c), {63'd0, mem_req[0]}, 64'd1);
      chk($sformatf("hold_addr_c%0d", c), {32'd0, mem_addr[0]}, 64'h3000);
      chk_rv(0, $sformatf("hold_rv_c%0d", c), 2'b00);
      chk($sformatf("hold_dat_c%0d", c), {rd_b0[0], rd_b1[0]}, 64'd0);
      nxt();
    end
    mem_gnt[0] = 1'b0; mem_rvalid[0] = 1'b1;
    mem_b0[0] = 32'hCAFE_0001; mem_b1[0] = 32'hCAFE_0002;
    sett();
    chk_rv(0, "hold_rsp", 2'b01);
    chk("hold_data", {rd_b0[0], rd_b1[0]}, 64'hCAFE_0001_CAFE_0002);
    nxt();
    mem_rvalid[0] = 1'b0; if_req[0] = 1'b0;

    // Reset during WAIT; memory answers two cycles later.
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_4000;
    nxt();
    mem_gnt[0] = 1'b1;
    sett();
    chk("rstw_req", {63'd0, mem_req[0]}, 64'd1);
    nxt();
    mem_gnt[0] = 1'b0; rst[0] = 1'b1; mem_rvalid[0] = 1'b0;
    sett();
    chk_idle(0, "rstw_in_rst");
    nxt();
    rst[0] = 1'b0; if_req[0] = 1'b0;
    sett();
    chk_idle(0, "rstw_after");
    nxt();
    mem_rvalid[0] = 1'b1; mem_b0[0] = 32'hDEAD_BEEF; mem_b1[0] = 32'hBEEF_DEAD;
    sett();
    chk_idle(0, "rstw_late_rv");
    nxt();
    mem_rvalid[0] = 1'b0;
    run_row(mk(0, N, Y, 32'h100, Y, 32'h200, 0, 0, 32'h0101_0101, 32'h0202_0202, N, 32'h100), 20);
    run_row(mk(0, N, N, 32'h100, Y, 32'h200, 0, 0, 32'h0303_0303, 32'h0404_0404, Y, 32'h200), 21);

`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
    // Timeout in WAIT; LSU arrives meanwhile and must wait for the drained response.
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_5000;
    nxt();
    mem_gnt[1] = 1'b1;
    sett();
    chk("tmo_req", {63'd0, mem_req[1]}, 64'd1);
    nxt();
    mem_gnt[1] = 1'b0; lsu_req[1] = 1'b1; lsu_addr[1] = 32'h0000_6000;
    for (int c = 2; c <= 4; c++) begin
      sett();
      chk_rv(1, $sformatf("tmo_quiet_c%0d", c), 2'b00);
      nxt();
    end
    mem_b0[1] = 32'h1357_9BDF; mem_b1[1] = 32'h2468_ACE0;
    sett();
    chk_rv(1, "tmo_rv", 2'b01);
    chk("tmo_err", {63'd0, err[1]}, 64'd1);
    chk("tmo_dat", {rd_b0[1], rd_b1[1]}, 64'd0);
    nxt();
    if_req[1] = 1'b0;
    for (int c = 6; c <= 7; c++) begin
      sett();
      chk($sformatf("drain_blk_c%0d", c), {62'd0, mem_req[1], if_rv[1] | lsu_rv[1]}, 64'd0);
      nxt();
    end
    mem_rvalid[1] = 1'b1;
    sett();
    chk_rv(1, "drain_swallow", 2'b00);
    chk("drain_err", {63'd0, err[1]}, 64'd0);
    nxt();
    mem_rvalid[1] = 1'b0;
    sett();
    chk("drain_idle", {63'd0, mem_req[1]}, 64'd0);
    nxt();
    mem_gnt[1] = 1'b1;
    sett();
    chk("post_req", {63'd0, mem_req[1]}, 64'd1);
    chk("post_addr", {32'd0, mem_addr[1]}, 64'h6000);
    nxt();
    mem_gnt[1] = 1'b0; mem_rvalid[1] = 1'b1;
    mem_b0[1] = 32'h600D_0001; mem_b1[1] = 32'h600D_0002;
    sett();
    chk_rv(1, "post_rsp", 2'b10);
    chk("post_data", {rd_b0[1], rd_b1[1], 31'd0, err[1]}, {32'h600D_0001, 32'h600D_0002, 32'd0});
    nxt();
    mem_rvalid[1] = 1'b0; lsu_req[1] = 1'b0;

    // Timeout while still ungranted: request stays up through DRAIN until gnt.
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_7000;
    nxt();
    for (int c = 1; c <= 4; c++) begin
      sett();
      chk($sformatf("tmo2_req_c%0d", c), {63'd0, mem_req[1]}, 64'd1);
      chk_rv(1, $sformatf("tmo2_quiet_c%0d", c), 2'b00);
      nxt();
    end
    sett();
    chk_rv(1, "tmo2_rv", 2'b01);
    chk("tmo2_err_req", {62'd0, err[1], mem_req[1]}, 64'd3);
    nxt();
    if_req[1] = 1'b0; mem_gnt[1] = 1'b1;
    sett();
    chk("tmo2_drain_req", {31'd0, mem_req[1], mem_addr[1]}, {31'd0, 1'b1, 32'h7000});
    nxt();
    mem_gnt[1] = 1'b0;
    sett();
    chk("tmo2_drain_gnt", {63'd0, mem_req[1]}, 64'd0);
    nxt();
    mem_rvalid[1] = 1'b1;
    sett();
    chk_rv(1, "tmo2_swallow", 2'b00);
    nxt();
    mem_rvalid[1] = 1'b0;
    sett();
    chk_idle(1, "tmo2_idle");
`endif

    // Random traffic against the arbitration rules.
    for (int d = 0; d < 2; d++) begin
      bit          ifr_m, lsur_m, last_lsu, win;
      logic [31:0] ifa_m, lsua_m;
      vec_t        v;
      ifr_m = 1'b0; lsur_m = 1'b0; last_lsu = 1'b1; ifa_m = '0; lsua_m = '0;
      for (int n = 0; (n < RAND_N) || ifr_m || lsur_m; n++) begin
        if (n < RAND_N) begin
          if (!ifr_m && ($urandom_range(1, 0) == 1)) begin ifr_m = 1'b1; ifa_m = $urandom; end
          if (!lsur_m && ($urandom_range(1, 0) == 1)) begin lsur_m = 1'b1; lsua_m = $urandom; end
          if (!ifr_m && !lsur_m) begin
            if ($urandom_range(1, 0) == 1) begin ifr_m = 1'b1; ifa_m = $urandom; end
            else begin lsur_m = 1'b1; lsua_m = $urandom; end
          end
        end
        if (ifr_m && lsur_m) win = (d == 0) ? !last_lsu : 1'b1;
        else win = lsur_m;
        v.dut = d; v.rst = (n == 0); v.ifr = ifr_m; v.ifa = ifa_m; v.lsur = lsur_m; v.lsua = lsua_m;
        v.gd = $urandom_range(2, 0);
        v.rd = $urandom_range(2 - v.gd, 0);
        v.b0 = $urandom; v.b1 = $urandom;
        v.exp_lsu = win;
        v.exp_addr = win ? lsua_m : ifa_m;
        run_row(v, 1000 * (d + 1) + n);
        last_lsu = win;
        if (win) lsur_m = 1'b0;
        else ifr_m = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e41s_pmp_imp_arbiter.md
Name: cv32e41s_pmp_imp_arbiter

Overview:
- Shares one implicit-access memory port between the IF-stage MPU and the LSU MPU.
- The port serves PMP table-walk reads, which return a two-beat result (b0/b1) per access.
- The block arbitrates the two requesters, issues one transaction at a time with an OBI-style req/gnt/rvalid handshake, and routes the response back to its owner.
- It sits between the two MPU instances and the implicit-access port of the bus interface.

Parameters:
- ARB_ROUND_ROBIN, 1, 1 = round-robin between IF and LSU; 0 = fixed priority, LSU wins.
- TIMEOUT_CYCLES, 255, response watchdog limit in cycles, range 1..65535. Used only with the optional feature.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- if_req_i  input  1  IF MPU implicit request; held until if_rvalid_o
- if_addr_i  input  32  IF request address; stable while if_req_i
- if_rvalid_o  output  1  response valid to IF MPU
- lsu_req_i  input  1  LSU MPU implicit request; held until lsu_rvalid_o
- lsu_addr_i  input  32  LSU request address; stable while lsu_req_i
- lsu_rvalid_o  output  1  response valid to LSU MPU
- rdata_b0_o  output  32  response beat 0, shared; meaningful only with an rvalid
- rdata_b1_o  output  32  response beat 1, shared
- err_o  output  1  response is a timeout error; qualified by rvalid
- mem_req_o  output  1  request to memory port
- mem_addr_o  output  32  request address
- mem_gnt_i  input  1  memory grant
- mem_rvalid_i  input  1  memory response valid
- mem_rdata_b0_i  input  32  memory beat 0
- mem_rdata_b1_i  input  32  memory beat 1

Behaviour:
- Reset is synchronous and active-high, applied at the rising edge of clk with rst=1.
  - State goes to IDLE; owner_q=IF; last_q=LSU, so IF wins the first tie.
  - addr_q is cleared to 0.
  - All outputs are 0 in reset and in IDLE.
  - Reset asserted mid-transaction abandons the transaction; no rvalid is produced.
- One transaction is outstanding at a time. FSM states:
  - IDLE, with any request:
    - Pick the winner.
    - Round-robin: on a tie, grant the requester that is not last_q.
    - Fixed priority: LSU wins.
    - Latch owner_q and addr_q at the edge, then go to REQ.
  - REQ:
    - mem_req_o=1 and mem_addr_o=addr_q, both registered.
    - On mem_gnt_i, go to WAIT. Otherwise hold.
  - WAIT:
    - mem_req_o=0.
    - On mem_rvalid_i, assert the owner's rvalid combinationally in the same cycle, with rdata_b0_o/b1_o passed through from memory and err_o=0.
    - Update last_q=owner_q and go to IDLE.
- Minimum latency: request sampled at edge 0; mem_req_o high in cycle 1; gnt in cycle 1; rvalid in cycle 2 reaches the owner in cycle 2.
- A new request can be accepted in the cycle after a response.
- Requesters drop req on seeing their rvalid. A req still high in IDLE is treated as a new request.
- Requests cannot be withdrawn.
  - If the owner drops req in REQ/WAIT, the transaction still completes and rvalid is still pulsed.
- The non-owner's request is held off with no side effects until the arbiter returns to IDLE.
- mem_rvalid_i is ignored in IDLE and REQ. Memory must not respond before gnt.
- mem_gnt_i is ignored outside REQ.
- rdata outputs are 0 whenever no rvalid is asserted. if_rvalid_o and lsu_rvalid_o are never high together.
- Round-robin with continuous requests from both sides strictly alternates.
- Fixed priority may starve IF; this is acceptable for that configuration.

Optional Feature:
- Macro: CV32E41S_PMP_IMP_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to REQ and increments each cycle in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES without completion, the arbiter pulses the owner's rvalid with err_o=1 and rdata=0, then enters DRAIN. If mem_rvalid_i arrives in that same cycle, the normal response wins and there is no timeout.
  - DRAIN: mem_req_o stays high while gnt is still pending. The arbiter waits for mem_rvalid_i, discards it (no rvalid to either requester), then goes to IDLE.
  - New requests are blocked during DRAIN.
- Undefined: no counter, no DRAIN state, and err_o is tied to 0.

Test Plan:
- Single IF request, addr 0x0000_1000; gnt in first REQ cycle; rvalid 1 cycle later with b0=0xA5A5_0001, b1=0x5A5A_0002 -> mem_req_o in cycle 1, if_rvalid_o in cycle 2 with matching data, lsu_rvalid_o=0.
- IF and LSU request together after reset (ARB_ROUND_ROBIN=1), addrs 0x100/0x200 -> IF is served first, then LSU. Continued requests from both alternate IF, LSU, IF.
- Same stimulus with ARB_ROUND_ROBIN=0 -> LSU (0x200) is served first, and LSU is served repeatedly while held.
- Gnt withheld for 5 cycles -> mem_req_o and mem_addr_o stay stable for 6 cycles. An rvalid injected during REQ is ignored.
- Reset asserted in WAIT, with a memory rvalid arriving 2 cycles later -> no requester rvalid; state is IDLE; all outputs 0.
- Macro defined, TIMEOUT_CYCLES=4, no response -> owner rvalid with err_o=1 4 cycles after REQ entry. A late mem_rvalid is swallowed, and only then is a pending LSU request granted.
